// File: rtl/sequencer_pkg.sv
// sequencer_pkg: shared state encoding and instruction constants for the program sequencer
package sequencer_pkg;
   localparam int IW = 16;
   localparam logic [IW-1:0] HALT_WORD = '0;
   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      HALT,
      FAULT
   } state_t;
endpackage

// File: rtl/instr_store.sv
// instr_store: DEPTH x IW register file, one synchronous write port, combinational read
module instr_store
   import sequencer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW = 4
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [IW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [IW-1:0] rdata
);
   logic [IW-1:0] mem [DEPTH];
   always_ff @(posedge clock)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: steps through the instruction store, handing each word to the core and waiting for done
module instr_sequencer
   import sequencer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW = 4,
   parameter int TIMEOUT = 64
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [IW-1:0] load_data,
   input  logic          start,
   input  logic          done,
   output logic [IW-1:0] iin,
   output logic          run,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          halted,
   output logic          fault
);
   localparam int TW = $clog2(TIMEOUT);
   state_t state, state_n;
   logic [AW-1:0] pc_n;
   logic [IW-1:0] iin_n, rdata;
   logic run_n, we, stopped;
   logic [TW-1:0] timer, timer_n;
   assign stopped = state == IDLE || state == HALT || state == FAULT;
   assign we = load_en && stopped;
   instr_store #(.DEPTH(DEPTH), .AW(AW)) u_store (
      .clock(clock),
      .we(we),
      .waddr(load_addr),
      .wdata(load_data),
      .raddr(pc),
      .rdata(rdata)
   );
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= IDLE;
         pc    <= '0;
         iin   <= '0;
         run   <= 1'b0;
         timer <= '0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         iin   <= iin_n;
         run   <= run_n;
         timer <= timer_n;
      end
   // a load on the same edge as start takes priority, so start is dropped
   always_comb begin
      state_n = state;
      pc_n    = pc;
      iin_n   = iin;
      run_n   = 1'b0;
      timer_n = timer;
      case (state)
         FETCH: begin
            state_n = rdata == HALT_WORD ? HALT : WAIT;
            iin_n   = rdata == HALT_WORD ? iin : rdata;
            run_n   = rdata != HALT_WORD;
            timer_n = '0;
         end
         WAIT: begin
            timer_n = timer + 1'b1;
            if (done && !run) begin
               state_n = pc == AW'(DEPTH - 1) ? HALT : FETCH;
               pc_n    = pc == AW'(DEPTH - 1) ? pc : pc + 1'b1;
            end else if (timer == TW'(TIMEOUT - 1)) begin
               state_n = FAULT;
            end
         end
         default: begin
            state_n = start && !load_en ? FETCH : state;
            pc_n    = start && !load_en ? '0 : pc;
         end
      endcase
   end
   assign busy   = state == FETCH || state == WAIT;
   assign halted = state == HALT;
   assign fault  = state == FAULT;
endmodule
